// File: rtl/clk_rate_alarm.sv
// clk_rate_alarm: single-channel threshold/alarm stage behind the clock monitor.
// Classifies each accepted rate sample against inclusive [cfg_min, cfg_max],
// debounces entry to and exit from ALARM, keeps sticky status bits, counts
// alarm entries (saturating) and drives a maskable level interrupt.
//
// Ports (all in the clk_ref domain):
//   clk_ref        reference clock, rising edge
//   aresetn        asynchronous active-low reset
//   rate           latest rate measurement (unsigned)
//   rate_valid     one-cycle pulse marking a new rate
//   unlocks        running unlock count; 0 means software-cleared
//   cfg_enable     1 = evaluate samples, 0 = hold FSM in INIT
//   cfg_min        inclusive lower limit
//   cfg_max        inclusive upper limit
//   cfg_irq_mask   per-bit enable of status_sticky into irq
//   clr_status     write-1-to-clear pulses for status_sticky
//   status_sticky  [0] rate_low, [1] rate_high, [2] unlock
//   alarm          debounced alarm level
//   state          INIT=0, OK=1, PEND_BAD=2, ALARM=3, PEND_OK=4
//   last_rate      last accepted sample
//   bad_count      number of entries into ALARM, saturating
//   irq            |(status_sticky & cfg_irq_mask)
module clk_rate_alarm #(
    parameter int unsigned RATE_W   = 32,
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk_ref,
    input  logic              aresetn,
    input  logic [RATE_W-1:0] rate,
    input  logic              rate_valid,
    input  logic [31:0]       unlocks,
    input  logic              cfg_enable,
    input  logic [RATE_W-1:0] cfg_min,
    input  logic [RATE_W-1:0] cfg_max,
    input  logic [2:0]        cfg_irq_mask,
    input  logic [2:0]        clr_status,
    output logic [2:0]        status_sticky,
    output logic              alarm,
    output logic [2:0]        state,
    output logic [RATE_W-1:0] last_rate,
    output logic [CNT_W-1:0]  bad_count,
    output logic              irq
);

    typedef enum logic [2:0] {
        StInit    = 3'd0,
        StOk      = 3'd1,
        StPendBad = 3'd2,
        StAlarm   = 3'd3,
        StPendOk  = 3'd4
    } state_e;

    localparam logic [7:0] DebLast = 8'(DEBOUNCE);
    localparam bit         DebOne  = (DEBOUNCE == 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              alarm_q, alarm_d;
    logic [2:0]        sticky_q, sticky_d;
    logic [RATE_W-1:0] last_rate_q, last_rate_d;
    logic [CNT_W-1:0]  bad_count_q, bad_count_d;
    logic [31:0]       prev_unlocks_q;
    logic              prev_valid_q;

    logic       accept;
    logic       low, high, bad;
    logic [7:0] cnt_inc;
    logic       enter_alarm;
    logic [2:0] set_bits;

    assign accept  = rate_valid & cfg_enable;
    assign low     = rate < cfg_min;
    // low has priority, so an inverted window reports every sample as low
    assign high    = !low && (rate > cfg_max);
    assign bad     = low | high;
    // cnt always stays below DEBOUNCE (<= 255), so this cannot wrap
    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!cfg_enable) begin
            state_d = StInit;
            cnt_d   = '0;
        end else if (rate_valid) begin
            case (state_q)
                StInit, StOk: begin
                    if (!bad) begin
                        state_d = StOk;
                        cnt_d   = '0;
                    end else if (DebOne) begin
                        state_d = StAlarm;
                        cnt_d   = '0;
                    end else begin
                        state_d = StPendBad;
                        cnt_d   = 8'd1;
                    end
                end
                StPendBad: begin
                    if (!bad) begin
                        state_d = StOk;
                        cnt_d   = '0;
                    end else if (cnt_inc == DebLast) begin
                        state_d = StAlarm;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                StAlarm: begin
                    if (bad) begin
                        cnt_d = '0;
                    end else if (DebOne) begin
                        state_d = StOk;
                        cnt_d   = '0;
                    end else begin
                        state_d = StPendOk;
                        cnt_d   = 8'd1;
                    end
                end
                StPendOk: begin
                    if (bad) begin
                        state_d = StAlarm;
                        cnt_d   = '0;
                    end else if (cnt_inc == DebLast) begin
                        state_d = StOk;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = StInit;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // PEND_OK -> ALARM is a bounce back, not a fresh alarm, so it is not counted
    assign enter_alarm = accept && (state_d == StAlarm) &&
                         ((state_q == StInit) || (state_q == StOk) || (state_q == StPendBad));

    always_comb begin
        alarm_d     = (state_d == StAlarm) || (state_d == StPendOk);
        last_rate_d = accept ? rate : last_rate_q;
        bad_count_d = bad_count_q;
        if (enter_alarm && (bad_count_q != '1)) begin
            bad_count_d = bad_count_q + 1'b1;
        end

        set_bits = 3'b000;
        if (accept && bad && (state_d == StAlarm)) begin
            set_bits[0] = low;
            set_bits[1] = !low;
        end
        // first cycle after reset only captures the count, nothing to compare against
        if (prev_valid_q && (unlocks != prev_unlocks_q) && (unlocks != '0)) begin
            set_bits[2] = 1'b1;
        end
        // set wins over a same-cycle clear
        sticky_d = (sticky_q & ~clr_status) | set_bits;
    end

    always_ff @(posedge clk_ref or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= StInit;
            cnt_q          <= '0;
            alarm_q        <= 1'b0;
            sticky_q       <= '0;
            last_rate_q    <= '0;
            bad_count_q    <= '0;
            prev_unlocks_q <= '0;
            prev_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            alarm_q        <= alarm_d;
            sticky_q       <= sticky_d;
            last_rate_q    <= last_rate_d;
            bad_count_q    <= bad_count_d;
            prev_unlocks_q <= unlocks;
            prev_valid_q   <= 1'b1;
        end
    end

    assign state         = state_q;
    assign alarm         = alarm_q;
    assign status_sticky = sticky_q;
    assign last_rate     = last_rate_q;
    assign bad_count     = bad_count_q;
    assign irq           = |(sticky_q & cfg_irq_mask);

endmodule

// File: tb/tb_clk_rate_alarm.sv
// Bench for clk_rate_alarm: table-driven samples through a scoreboard queue on a
// DEBOUNCE=3 instance, plus hand-written sequences for unlock/clear, inverted
// limits, counter saturation (DEBOUNCE=1, CNT_W=4 instance) and async reset.
module tb_clk_rate_alarm;

    typedef struct {
        logic [31:0] rate;
        logic        valid;
        logic        en;
        logic [31:0] min;
        logic [31:0] max;
        logic [2:0]  st;
        logic        al;
        logic [15:0] bc;
        logic [2:0]  sticky;
        logic [31:0] last;
    } vec_t;

    typedef struct {
        int          idx;
        logic [2:0]  st;
        logic        al;
        logic [15:0] bc;
        logic [2:0]  sticky;
        logic [31:0] last;
    } exp_t;

    int checks = 0;
    int failures = 0;

    logic clk_ref = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk_ref = ~clk_ref;

    // instance 0: DEBOUNCE=3, CNT_W=16
    logic [31:0] rate = '0;
    logic        rate_valid = 1'b0;
    logic [31:0] unlocks = '0;
    logic        cfg_enable = 1'b1;
    logic [31:0] cfg_min = 32'd99;
    logic [31:0] cfg_max = 32'd101;
    logic [2:0]  cfg_irq_mask = '0;
    logic [2:0]  clr_status = '0;
    logic [2:0]  status_sticky;
    logic        alarm;
    logic [2:0]  state;
    logic [31:0] last_rate;
    logic [15:0] bad_count;
    logic        irq;

    // instance 1: DEBOUNCE=1, CNT_W=4
    logic [31:0] rate1 = '0;
    logic        valid1 = 1'b0;
    logic [31:0] unlocks1 = '0;
    logic        en1 = 1'b1;
    logic [31:0] min1 = 32'd200;
    logic [31:0] max1 = 32'd100;
    logic [2:0]  mask1 = '0;
    logic [2:0]  clr1 = '0;
    logic [2:0]  sticky1;
    logic        alarm1;
    logic [2:0]  state1;
    logic [31:0] last1;
    logic [3:0]  bc1;
    logic        irq1;

    clk_rate_alarm #(.RATE_W(32), .DEBOUNCE(3), .CNT_W(16)) dut (
        .clk_ref      (clk_ref),
        .aresetn      (aresetn),
        .rate         (rate),
        .rate_valid   (rate_valid),
        .unlocks      (unlocks),
        .cfg_enable   (cfg_enable),
        .cfg_min      (cfg_min),
        .cfg_max      (cfg_max),
        .cfg_irq_mask (cfg_irq_mask),
        .clr_status   (clr_status),
        .status_sticky(status_sticky),
        .alarm        (alarm),
        .state        (state),
        .last_rate    (last_rate),
        .bad_count    (bad_count),
        .irq          (irq)
    );

    clk_rate_alarm #(.RATE_W(32), .DEBOUNCE(1), .CNT_W(4)) dut1 (
        .clk_ref      (clk_ref),
        .aresetn      (aresetn),
        .rate         (rate1),
        .rate_valid   (valid1),
        .unlocks      (unlocks1),
        .cfg_enable   (en1),
        .cfg_min      (min1),
        .cfg_max      (max1),
        .cfg_irq_mask (mask1),
        .clr_status   (clr1),
        .status_sticky(sticky1),
        .alarm        (alarm1),
        .state        (state1),
        .last_rate    (last1),
        .bad_count    (bc1),
        .irq          (irq1)
    );

    vec_t vecs[$];
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic add(input logic [31:0] r, input logic v, input logic e,
                       input logic [31:0] mn, input logic [31:0] mx, input logic [2:0] st,
                       input logic al, input logic [15:0] bc, input logic [2:0] sk,
                       input logic [31:0] last);
        vec_t x;
        x.rate = r; x.valid = v; x.en = e; x.min = mn; x.max = mx;
        x.st = st; x.al = al; x.bc = bc; x.sticky = sk; x.last = last;
        vecs.push_back(x);
    endtask

    task automatic push_exp(input int idx, input vec_t x);
        exp_t e;
        e.idx = idx; e.st = x.st; e.al = x.al; e.bc = x.bc; e.sticky = x.sticky; e.last = x.last;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_ref);
        #1;
    endtask

    // Scoreboard consumer: one expected record per clock edge while the table runs.
    always @(posedge clk_ref) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("vec%0d.state", e.idx), 64'(state), 64'(e.st));
            check($sformatf("vec%0d.alarm", e.idx), 64'(alarm), 64'(e.al));
            check($sformatf("vec%0d.bad_count", e.idx), 64'(bad_count), 64'(e.bc));
            check($sformatf("vec%0d.sticky", e.idx), 64'(status_sticky), 64'(e.sticky));
            check($sformatf("vec%0d.last_rate", e.idx), 64'(last_rate), 64'(e.last));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [3:0] exp_bc;

        //   rate  v  en  min  max  st al bc sticky last
        add(32'd99,  1, 1, 99, 101, 1, 0, 0, 3'b000, 99);   // inclusive low edge
        add(32'd101, 1, 1, 99, 101, 1, 0, 0, 3'b000, 101);  // inclusive high edge
        add(32'd98,  1, 1, 99, 101, 2, 0, 0, 3'b000, 98);
        add(32'd102, 1, 1, 99, 101, 2, 0, 0, 3'b000, 102);
        add(32'd100, 1, 1, 99, 101, 1, 0, 0, 3'b000, 100);  // good resets debounce
        add(32'd120, 1, 1, 99, 101, 2, 0, 0, 3'b000, 120);
        add(32'd120, 1, 1, 99, 101, 2, 0, 0, 3'b000, 120);
        add(32'd120, 1, 1, 99, 101, 3, 1, 1, 3'b010, 120);
        add(32'd100, 1, 1, 99, 101, 4, 1, 1, 3'b010, 100);
        add(32'd50,  1, 1, 99, 101, 3, 1, 1, 3'b011, 50);   // bounce back, not counted
        add(32'd100, 1, 1, 99, 101, 4, 1, 1, 3'b011, 100);
        add(32'd100, 1, 1, 99, 101, 4, 1, 1, 3'b011, 100);
        add(32'd100, 1, 1, 99, 101, 1, 0, 1, 3'b011, 100);
        add(32'd120, 1, 1, 99, 101, 2, 0, 1, 3'b011, 120);
        add(32'd120, 1, 1, 99, 101, 2, 0, 1, 3'b011, 120);
        add(32'd0,   0, 0, 99, 101, 0, 0, 1, 3'b011, 120);  // disable mid-PEND_BAD
        add(32'd130, 1, 0, 99, 101, 0, 0, 1, 3'b011, 120);  // ignored sample
        add(32'd120, 1, 1, 99, 101, 2, 0, 1, 3'b011, 120);
        add(32'd120, 1, 1, 99, 101, 2, 0, 1, 3'b011, 120);
        add(32'd120, 1, 1, 99, 101, 3, 1, 2, 3'b011, 120);
        add(32'd0,   0, 0, 99, 101, 0, 0, 2, 3'b011, 120);  // disable mid-ALARM
        add(32'd100, 1, 1, 99, 101, 1, 0, 2, 3'b011, 100);
        add(32'd100, 1, 1, 150, 200, 2, 0, 2, 3'b011, 100); // new limits apply now
        add(32'd160, 1, 1, 150, 200, 1, 0, 2, 3'b011, 160);

        #2;
        check("reset.state", 64'(state), 64'd0);
        check("reset.alarm", 64'(alarm), 64'd0);
        check("reset.sticky", 64'(status_sticky), 64'd0);
        check("reset.last_rate", 64'(last_rate), 64'd0);
        check("reset.bad_count", 64'(bad_count), 64'd0);
        check("reset.irq", 64'(irq), 64'd0);
        @(negedge clk_ref);
        aresetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_ref);
            rate = vecs[i].rate; rate_valid = vecs[i].valid; cfg_enable = vecs[i].en;
            cfg_min = vecs[i].min; cfg_max = vecs[i].max;
            push_exp(i, vecs[i]);
            @(negedge clk_ref);
            rate_valid = 1'b0;       // idle cycle must not move anything
            push_exp(i, vecs[i]);
        end
        @(posedge clk_ref);
        #2;
        check("scoreboard.drained", 64'(exp_q.size()), 64'd0);

        // unlock sticky bit, clear and set-over-clear
        @(negedge clk_ref); cfg_irq_mask = 3'b100; unlocks = 32'd5;
        step(); check("unl.set", 64'(status_sticky), 64'b111); check("unl.irq1", 64'(irq), 64'd1);
        @(negedge clk_ref); unlocks = 32'd0;
        step(); check("unl.swclr", 64'(status_sticky), 64'b111);
        @(negedge clk_ref); clr_status = 3'b100;
        step(); check("clr.bit2", 64'(status_sticky), 64'b011); check("clr.irq0", 64'(irq), 64'd0);
        @(negedge clk_ref); clr_status = 3'b100; unlocks = 32'd1;
        step(); check("setwins", 64'(status_sticky), 64'b111); check("setwins.irq", 64'(irq), 64'd1);
        @(negedge clk_ref); clr_status = 3'b001;
        step(); check("clr.bit0", 64'(status_sticky), 64'b110);
        @(negedge clk_ref); clr_status = 3'b000;
        step(); check("hold", 64'(status_sticky), 64'b110);

        // inverted limits with DEBOUNCE=1: immediate ALARM, reported as low
        @(negedge clk_ref); rate1 = 32'd150; valid1 = 1'b1;
        step();
        check("inv.state", 64'(state1), 64'd3);
        check("inv.alarm", 64'(alarm1), 64'd1);
        check("inv.sticky", 64'(sticky1), 64'b001);
        check("inv.bad_count", 64'(bc1), 64'd1);

        // saturate the 4-bit entry counter
        exp_bc = 4'd1;
        min1 = 32'd99; max1 = 32'd101;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk_ref); rate1 = 32'd100;
            step(); check("sat.ok", 64'(state1), 64'd1);
            @(negedge clk_ref); rate1 = 32'd120;
            exp_bc = (exp_bc == 4'hf) ? 4'hf : exp_bc + 4'd1;
            step(); check("sat.alarm", 64'(state1), 64'd3);
            check($sformatf("sat.bc%0d", i), 64'(bc1), 64'(exp_bc));
        end
        @(negedge clk_ref); valid1 = 1'b0;
        check("sat.final", 64'(bc1), 64'hf);

        // drive instance 0 into ALARM, then reset asynchronously between edges
        @(negedge clk_ref); cfg_min = 32'd150; cfg_max = 32'd200; rate = 32'd300; rate_valid = 1'b1;
        step(); step(); step();
        @(negedge clk_ref); rate_valid = 1'b0;
        check("pre_rst.alarm", 64'(alarm), 64'd1);
        check("pre_rst.bc", 64'(bad_count), 64'd3);
        @(posedge clk_ref);
        #3;
        aresetn = 1'b0;
        unlocks = 32'd7;
        #1;
        check("arst.state", 64'(state), 64'd0);
        check("arst.alarm", 64'(alarm), 64'd0);
        check("arst.sticky", 64'(status_sticky), 64'd0);
        check("arst.last_rate", 64'(last_rate), 64'd0);
        check("arst.bad_count", 64'(bad_count), 64'd0);
        check("arst.irq", 64'(irq), 64'd0);
        check("arst.bc1", 64'(bc1), 64'd0);
        @(negedge clk_ref); aresetn = 1'b1;
        step(); step();
        check("post_rst.noload_cmp", 64'(status_sticky), 64'b000);
        @(negedge clk_ref); unlocks = 32'd8;
        step();
        check("post_rst.unl", 64'(status_sticky), 64'b100);
        check("post_rst.irq", 64'(irq), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_rate_alarm.md
Name: clk_rate_alarm

Overview:
- Single-channel threshold and alarm stage directly downstream of the clock monitor.
- Consumes the per-window rate measurement and the unlock count for one monitored clock, all in the clk_ref domain.
- Applies programmable min/max limits with N-sample debounce, keeps sticky status bits and a saturating alarm-entry counter, and drives a maskable level interrupt.

Parameters:
- RATE_W, 32, width of rate, cfg_min, cfg_max and last_rate.
- DEBOUNCE, 3, consecutive accepted samples needed to enter or leave ALARM; legal range 1..255.
- CNT_W, 16, width of bad_count.

Ports:
- clk_ref  in  1  reference clock; all logic on its rising edge.
- aresetn  in  1  asynchronous active-low reset.
- rate  in  RATE_W  latest rate measurement, unsigned.
- rate_valid  in  1  one-cycle pulse when rate holds a new measurement.
- unlocks  in  32  running unlock count from the monitor; 0 means software-cleared.
- cfg_enable  in  1  1 = evaluate samples; 0 = hold FSM in INIT.
- cfg_min  in  RATE_W  inclusive lower limit.
- cfg_max  in  RATE_W  inclusive upper limit.
- cfg_irq_mask  in  3  per-bit enable of status_sticky into irq.
- clr_status  in  3  one-cycle write-1-to-clear pulses for status_sticky.
- status_sticky  out  3  sticky flags: [0] rate_low, [1] rate_high, [2] unlock.
- alarm  out  1  debounced alarm level.
- state  out  3  FSM encoding: INIT=0, OK=1, PEND_BAD=2, ALARM=3, PEND_OK=4.
- last_rate  out  RATE_W  last accepted sample.
- bad_count  out  CNT_W  number of entries into ALARM, saturating.
- irq  out  1  interrupt level, |(status_sticky & cfg_irq_mask).

Behaviour:
- Reset values (asynchronous, aresetn=0): state=INIT, alarm=0, status_sticky=0, last_rate=0, bad_count=0, debounce counter=0, prev_valid=0; therefore irq=0.
- A sample is accepted when rate_valid=1 and cfg_enable=1.
  - On acceptance, last_rate <= rate.
  - FSM, sticky bits and counter are updated on the same edge; results are visible the cycle after the rate_valid pulse.
- Classification (unsigned compare):
  - low = rate < cfg_min.
  - high = !low && rate > cfg_max.
  - bad = low | high.
  - If cfg_min > cfg_max, every sample is bad; low takes priority.
- FSM transitions on accepted samples (cnt is the debounce counter):
  - INIT: good -> OK. Bad -> PEND_BAD with cnt=1, or straight to ALARM if DEBOUNCE=1.
  - OK: good -> stay. Bad -> same as the bad case from INIT.
  - PEND_BAD: bad -> cnt+1; when cnt+1 == DEBOUNCE -> ALARM and cnt=0. Good -> OK with cnt=0.
  - ALARM: bad -> stay. Good -> PEND_OK with cnt=1, or straight to OK if DEBOUNCE=1.
  - PEND_OK: good -> cnt+1; when cnt+1 == DEBOUNCE -> OK and cnt=0. Bad -> ALARM with cnt=0.
- Non-accepted cycles leave the FSM unchanged.
- alarm = (state==ALARM) | (state==PEND_OK), registered with state.
- bad_count increments by 1 on every transition into ALARM from INIT, OK or PEND_BAD. It does not increment on PEND_OK -> ALARM. It saturates at all-ones and is cleared only by reset.
- Sticky rate bits: on an accepted bad sample whose next state is ALARM, set bit0 if low, else bit1.
- Sticky unlock bit (bit2):
  - The first cycle after reset loads prev_unlocks <= unlocks and sets prev_valid, with no compare.
  - After that, each cycle: if unlocks != prev_unlocks and unlocks != 0, set bit2.
  - prev_unlocks <= unlocks every cycle; a change to 0 is a software clear and never sets bit2.
  - The unlock path is independent of cfg_enable.
- clr_status[k]=1 clears bit k on the next edge. A same-cycle set wins over clear.
- cfg_enable=0: on the next edge state=INIT and cnt=0. status_sticky, last_rate and bad_count are held. An alarm in progress drops to 0 with no count.
- Samples arriving while cfg_enable=0 are ignored. Changing cfg_min/cfg_max takes effect from the next accepted sample and does not re-evaluate past samples.
- irq is combinational from registered status_sticky and cfg_irq_mask, so there is no extra latency beyond the sticky bit.

Test Plan:
1. DEBOUNCE=3, min=99, max=101, enable. Samples 100, 120, 120, 120 -> states OK, PEND_BAD, PEND_BAD, ALARM. alarm=1 one cycle after the 4th pulse; bad_count=1; status_sticky=3'b010.
2. From ALARM, samples 100, 50, 100, 100, 100 -> PEND_OK, ALARM, PEND_OK, PEND_OK, OK. bad_count stays 1; alarm=0 after the last; status_sticky=3'b011.
3. unlocks 0 -> 5: bit2 set, and with mask=3'b100 irq=1. unlocks 5 -> 0: bit2 unchanged. Pulse clr_status=3'b100 -> bit2=0, irq=0. Assert clr_status[2] on the same cycle unlocks changes 0 -> 1 -> bit2=1.
4. min=200, max=100 (inverted), DEBOUNCE=1, sample 150 -> ALARM in 1 sample; bit0 (low) set, bit1 clear.
5. In PEND_BAD with cnt=2, drop cfg_enable -> state=INIT, alarm=0. Sample 120 with enable low -> ignored, last_rate unchanged. Re-enable, sample 120 -> PEND_BAD with cnt=1.
6. Assert aresetn=0 mid-ALARM, asynchronously between clock edges -> all outputs 0 immediately. Force bad_count to 0xFFFF via repeated ALARM entries -> stays 0xFFFF on the next entry.
